kvs_cmd_arbiter: RTL

KVS_CMD_ARBITER -- requirements
Module: kvs_cmd_arbiter

---
 rtl/kvs_pkg.sv | 33 +++
 rtl/kvs_tag_fifo.sv | 50 +++++
 rtl/kvs_cmd_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/kvs_pkg.sv
// Shared types and constants for the KVS kernel command path.
package kvs_pkg;

  localparam int unsigned KVS_CMD_W = 300;
  localparam int unsigned KVS_RSP_W = 512;

  // One-hot bit positions within kvs_cmd_t.op
  localparam int unsigned OP_ERASE  = 0;
  localparam int unsigned OP_WRITE  = 1;
  localparam int unsigned OP_READ   = 2;
  localparam int unsigned OP_SEARCH = 3;
  localparam int unsigned OP_UPDATE = 4;

  typedef struct packed {
    logic [127:0] key;
    logic [127:0] msk;
    logic [31:0]  value;
    logic [6:0]   pri;
    logic [4:0]   op;
  } kvs_cmd_t;

  typedef enum logic [1:0] {
    WAIT_READY,
    RUN,
    DRAIN
  } arb_state_t;

  // Index width that stays at least one bit for a single requester.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kvs_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each unacked command.
module kvs_tag_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_ff @(posedge aclk) begin
    if (areset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/kvs_cmd_arbiter.sv
// Round-robin arbiter multiplexing requesters onto one KVS command port,
// routing in-order kernel responses back to the requester that issued them.
module kvs_cmd_arbiter
  import kvs_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_DEPTH = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*KVS_CMD_W-1:0]   req_cmd,
  input  logic                           kvs_ready,
  input  logic                           kvs_cmd_full,
  output logic                           kvs_valid,
  output logic [KVS_CMD_W-1:0]           kvs_cmd,
  input  logic                           kvs_ack,
  input  logic [KVS_RSP_W-1:0]           kvs_rsp,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [KVS_RSP_W-1:0]           rsp_data,
  input  logic                           drain_req,
  output logic                           drain_done,
  output logic [$clog2(TAG_DEPTH):0]     outstanding,
  output logic                           err_orphan
);

  localparam int unsigned TAG_W = idx_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(TAG_DEPTH);

  arb_state_t           state_q, state_d;
  logic [TAG_W-1:0]     ptr_q, ptr_d;
  logic [TAG_W-1:0]     grant_idx, tag_head;
  logic                 grant_found, can_issue, xfer, pop, orphan;
  logic [CNT_W-1:0]     tag_count;
  logic                 kvs_valid_q;
  kvs_cmd_t             kvs_cmd_q, sel_cmd;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [KVS_RSP_W-1:0] rsp_data_q;
  logic                 err_orphan_q;
  logic                 drain_done_c;
  int unsigned          cand;

  // State transitions plus the state-derived issue/drain qualifiers
  always_comb begin
    state_d      = state_q;
    can_issue    = 1'b0;
    drain_done_c = 1'b0;
    if (!kvs_ready) begin
      state_d = WAIT_READY;
    end else begin
      case (state_q)
        WAIT_READY: state_d = RUN;
        RUN:        if (drain_req) state_d = DRAIN;
        DRAIN:      if (!drain_req) state_d = RUN;
        default:    state_d = WAIT_READY;
      endcase
    end
    if (state_q == RUN && !kvs_cmd_full && tag_count < DEPTH_CNT) can_issue = 1'b1;
    if (state_q == DRAIN && tag_count == '0) drain_done_c = 1'b1;
  end

  // Search begins at ptr_q and wraps; the first valid requester wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_found && req_valid[cand[TAG_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (can_issue && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign xfer   = can_issue && grant_found;
  // A falling kvs_ready flushes the tags, so an ack in that cycle has no owner
  assign pop    = kvs_ack && kvs_ready && (tag_count != '0);
  assign orphan = kvs_ack && (tag_count == '0);

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
  end

  always_comb begin
    sel_cmd = req_cmd[KVS_CMD_W-1:0];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TAG_W'(i)) sel_cmd = req_cmd[i*KVS_CMD_W +: KVS_CMD_W];
    end
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = pop && (tag_head == TAG_W'(i));
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= WAIT_READY;
      ptr_q        <= '0;
      kvs_valid_q  <= 1'b0;
      rsp_valid_q  <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      kvs_valid_q <= xfer;
      rsp_valid_q <= rsp_valid_d;
      if (orphan) err_orphan_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (xfer) kvs_cmd_q  <= sel_cmd;
    if (pop)  rsp_data_q <= kvs_rsp;
  end

  kvs_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .aclk        (aclk),
    .areset      (areset),
    .flush_i     (~kvs_ready),
    .push_i      (xfer),
    .push_data_i (grant_idx),
    .pop_i       (pop),
    .pop_data_o  (tag_head),
    .count_o     (tag_count)
  );

  assign kvs_valid   = kvs_valid_q;
  assign kvs_cmd     = kvs_cmd_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign drain_done  = drain_done_c;
  assign outstanding = tag_count;
  assign err_orphan  = err_orphan_q;

endmodule
